// File: rtl/multdiv_pkg.sv
// Shared constants for the multdiv datapath: operation encodings and default sizes.
package multdiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_BLOCK = 8;
  localparam int unsigned DEF_TAG_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_block.sv
// One BLOCK-wide two-level carry-lookahead slice; purely combinational.
module cla_block #(
  parameter int unsigned BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb,
  output logic             allp
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Every carry is expanded directly from g/p and cin, not chained from the previous carry.
  always_comb begin
    logic pp;
    logic cc;
    c    = '0;
    pp   = 1'b1;
    cc   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      pp = 1'b1;
      cc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & cin);
    end
  end

  assign sum  = a ^ b ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];
  assign allp = &p;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-wide lookahead block per stage,
// with a valid/ready handshake where a full-pipe stall freezes every stage.
module pipelined_cla_addsub
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_allp,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned NBLK = (BLOCK > 0) ? WIDTH / BLOCK : 1;

  generate
    if ((BLOCK < 1) || ((WIDTH % ((BLOCK > 0) ? BLOCK : 1)) != 0)) begin : g_bad_cfg
      $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of BLOCK");
    end
  endgenerate

  logic [NBLK-1:0]            vld_q, vld_d;
  logic [NBLK-1:0]            carry_q, carry_d;
  logic [NBLK-1:0]            allp_q, allp_d;
  logic [NBLK-1:0]            cmsb_q, cmsb_d;
  logic [NBLK-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NBLK-1:0][WIDTH-1:0] a_q, a_d;
  logic [NBLK-1:0][WIDTH-1:0] b_q, b_d;
  logic [NBLK-1:0][WIDTH-1:0] sum_q, sum_d;

  logic [NBLK-1:0][BLOCK-1:0] blk_a, blk_b, blk_sum;
  logic [NBLK-1:0]            blk_cin, blk_cout, blk_cmsb, blk_allp;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;
  logic             unused_ok;

  assign b_eff = (in_sub == OP_ADD) ? in_b : ~in_b;
  assign c0    = (in_sub == OP_SUB) ? ~in_cin : in_cin;
  assign stall = vld_q[NBLK-1] & ~out_ready;

  // Block k reads its operand slice and carry from stage k-1; block 0 reads the live inputs.
  generate
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
      if (k == 0) begin : g_first
        assign blk_a[k]   = in_a[BLOCK-1:0];
        assign blk_b[k]   = b_eff[BLOCK-1:0];
        assign blk_cin[k] = c0;
      end else begin : g_rest
        assign blk_a[k]   = a_q[k-1][k*BLOCK +: BLOCK];
        assign blk_b[k]   = b_q[k-1][k*BLOCK +: BLOCK];
        assign blk_cin[k] = carry_q[k-1];
      end
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a    (blk_a[k]),
        .b    (blk_b[k]),
        .cin  (blk_cin[k]),
        .sum  (blk_sum[k]),
        .cout (blk_cout[k]),
        .cmsb (blk_cmsb[k]),
        .allp (blk_allp[k])
      );
    end
  endgenerate

  always_comb begin
    vld_d   = vld_q;
    carry_d = carry_q;
    allp_d  = allp_q;
    cmsb_d  = cmsb_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (!stall) begin
      vld_d[0]            = in_valid;
      tag_d[0]            = in_tag;
      a_d[0]              = in_a;
      b_d[0]              = b_eff;
      carry_d[0]          = blk_cout[0];
      allp_d[0]           = blk_allp[0];
      cmsb_d[0]           = blk_cmsb[0];
      sum_d[0]            = '0;
      sum_d[0][BLOCK-1:0] = blk_sum[0];
      for (int k = 1; k < NBLK; k++) begin
        vld_d[k]                   = vld_q[k-1];
        tag_d[k]                   = tag_q[k-1];
        a_d[k]                     = a_q[k-1];
        b_d[k]                     = b_q[k-1];
        carry_d[k]                 = blk_cout[k];
        allp_d[k]                  = allp_q[k-1] & blk_allp[k];
        cmsb_d[k]                  = blk_cmsb[k];
        sum_d[k]                   = sum_q[k-1];
        sum_d[k][k*BLOCK +: BLOCK] = blk_sum[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      carry_q <= '0;
      allp_q  <= '0;
      cmsb_q  <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      allp_q  <= allp_d;
      cmsb_q  <= cmsb_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // Last-stage operands and per-stage MSB carries of inner blocks have no consumer.
  assign unused_ok = ^{a_q[NBLK-1], b_q[NBLK-1], cmsb_q};

  assign in_ready  = ~stall;
  assign out_valid = vld_q[NBLK-1];
  assign out_sum   = sum_q[NBLK-1];
  assign out_cout  = carry_q[NBLK-1];
  assign out_ovf   = carry_q[NBLK-1] ^ cmsb_q[NBLK-1];
  assign out_allp  = allp_q[NBLK-1];
  assign out_tag   = tag_q[NBLK-1];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub (WIDTH=32, BLOCK=8, four-stage latency).
module tb_pipelined_cla_addsub;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BLOCK = 8;
  localparam int unsigned TAG_W = 4;
  localparam int          LAT   = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_allp;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_allp  (out_allp),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [3:0] tag);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0 ||
        out_allp !== 1'b0 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b allp=%b tag=%h expected all 0",
               out_valid, out_sum, out_cout, out_ovf, out_allp, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  // Single operation through an idle pipe: latency and every result field.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [3:0] tag,
                        input logic [31:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input logic exp_allp);
    int lat;
    out_ready = 1'b1;
    drive(1'b1, a, b, cin, sub, tag);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    checks++;
    if (out_sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, out_sum, exp_sum);
    end
    checks++;
    if (out_cout !== exp_cout || out_ovf !== exp_ovf || out_allp !== exp_allp) begin
      errors++;
      $display("FAIL %s flags: got cout=%b ovf=%b allp=%b expected cout=%b ovf=%b allp=%b",
               name, out_cout, out_ovf, out_allp, exp_cout, exp_ovf, exp_allp);
    end
    checks++;
    if (out_tag !== tag) begin
      errors++;
      $display("FAIL %s tag: got %h expected %h", name, out_tag, tag);
    end
    tick();
  endtask

  task automatic test_add();
    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h2, 32'h80000000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_neg",   32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'h3, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos",   32'h00000007, 32'h00000005, 1'b0, 1'b1, 4'h4, 32'h00000002, 1'b1, 1'b0, 1'b1);
    run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'h5, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_borrow",32'h00000005, 32'h00000002, 1'b1, 1'b1, 4'h6, 32'h00000002, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_propagate();
    run_op("allp_cin1", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'h7, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("allp_cin0", 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 4'h8, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
  endtask

  // Six ops (tag t: A=16t, B=t, so sum=17t); out_ready dropped for 3 cycles at first result.
  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    int low_ready = 0;
    int cyc = 0;
    int extra = 0;
    logic started = 1'b0;
    logic acc;
    logic [31:0] held_sum;
    logic [3:0]  held_tag;
    out_ready = 1'b1;
    while (got < 6 && cyc < 40) begin
      if (out_valid === 1'b1 && !started) begin
        started    = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      if (sent < 6 && stall_left > 0)
        drive(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, 4'hF);
      else if (sent < 6)
        drive(1'b1, 32'(sent * 16), 32'(sent), 1'b0, 1'b0, 4'(sent));
      else
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
      #1;
      checks++;
      if (in_ready !== (stall_left == 0)) begin
        errors++;
        $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", cyc, in_ready, stall_left == 0);
      end
      if (in_ready === 1'b0) low_ready++;
      if (stall_left == 3) begin
        held_sum = out_sum;
        held_tag = out_tag;
      end else if (stall_left > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== held_sum || out_tag !== held_tag) begin
          errors++;
          $display("FAIL b2b_hold cycle %0d: got valid=%b sum=%h tag=%h expected 1 %h %h",
                   cyc, out_valid, out_sum, out_tag, held_sum, held_tag);
        end
      end
      acc = in_valid && (stall_left == 0);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_tag !== 4'(got) || out_sum !== 32'(got * 17)) begin
          errors++;
          $display("FAIL b2b_result %0d: got tag=%h sum=%h expected tag=%h sum=%h",
                   got, out_tag, out_sum, 4'(got), 32'(got * 17));
        end
        got++;
      end
      @(posedge clock);
      #1;
      cyc++;
      if (acc) sent++;
      if (stall_left > 0) stall_left--;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    out_ready = 1'b1;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 6 (cycle budget)", got);
    end
    checks++;
    if (low_ready != 3) begin
      errors++;
      $display("FAIL b2b_stall_cycles: got %0d expected 3", low_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_duplicate: got %0d extra valid cycles expected 0", extra);
    end
  endtask

  // Four ops in flight, asynchronous reset between edges, then a fresh op.
  task automatic test_reset_midflight();
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h01010101 * 32'(i + 1), 32'h00000100, 1'b0, 1'b0, 4'(9 + i));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h9 || out_sum !== 32'h01010201) begin
      errors++;
      $display("FAIL midflight_pre: got valid=%b tag=%h sum=%h expected 1 9 01010201",
               out_valid, out_tag, out_sum);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0 ||
        out_allp !== 1'b0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_async: got valid=%b sum=%h cout=%b ovf=%b allp=%b tag=%h rdy=%b expected 0s rdy=1",
               out_valid, out_sum, out_cout, out_ovf, out_allp, out_tag, in_ready);
    end
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midflight_stale: got %0d valid cycles expected 0", stale);
    end
    run_op("post_reset", 32'h00001234, 32'h00004321, 1'b0, 1'b0, 4'hA, 32'h00005555, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_propagate();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the multdiv datapath. Successor to the fixed 8-bit lookahead adder.
- Splits a WIDTH-bit operation into WIDTH/BLOCK lookahead blocks and resolves one block per pipeline stage, so the clock period is set by a single BLOCK-wide lookahead.
- Adds a subtract mode, signed overflow, a valid/ready handshake with backpressure, and a tag carried alongside each operation.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per stage by one lookahead block.
- TAG_W, 4, width of the opaque tag carried with each operation.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all pipeline state.
- in_valid  input  1  operation presented on in_* this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for add; borrow-in for subtract.
- in_sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- in_tag  input  TAG_W  returned unchanged with the result.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of the MSB. For subtract: 1 = no borrow.
- out_ovf  output  1  signed overflow.
- out_allp  output  1  AND over all bits of (A | B_eff).
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Derived constant: NBLK = WIDTH/BLOCK.
- Effective operands:
  - B_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? ~in_cin : in_cin.
- Generate/propagate are g = a&b and p = a|b per bit. Each block computes full two-level lookahead carries internally from c_in, plus the block carry-out.
- Pipeline structure:
  - NBLK stages. Stage k (k = 0..NBLK-1) resolves bits [k*BLOCK +: BLOCK] using the carry registered by stage k-1 (stage 0 uses c0).
  - Each stage register holds: valid, tag, carry, partial sum of blocks 0..k, the unresolved upper operand blocks, the running allp, and the carry into bit WIDTH-1.
- Latency: an operation accepted at edge N appears on out_* after edge N+NBLK, provided out_ready stayed high.
- Throughput: one operation per cycle when unstalled.
- Stall rule: stall = out_valid & ~out_ready.
  - While stall is high, every stage register holds and in_ready = 0.
  - Otherwise in_ready = 1 and all stages advance together.
  - Bubbles are not compressed.
- Accept: the operation is accepted when in_valid & in_ready. When in_valid is low on an advancing edge, a bubble (valid = 0) enters stage 0.
- Result flags:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_allp = AND of (a | b_eff) over all WIDTH bits.
- out_* data fields are don't-care while out_valid = 0, but must be driven, never X after reset.
- Reset: asserting reset immediately (asynchronously) clears all stage valids and data to 0. Therefore out_valid = 0, out_sum = 0, out_cout = out_ovf = out_allp = 0, out_tag = 0 and in_ready = 1. In-flight operations are discarded, not completed.
- Boundary conditions:
  - NBLK = 1 degenerates to a single-register adder with latency 1.
  - A new operation may be accepted on the same edge the oldest result is consumed.
  - in_* are sampled only on accept; changing them while in_ready = 0 has no effect.
- Elaboration must fail (generate-time error) if WIDTH % BLOCK != 0 or if BLOCK < 1.

Decomposition:
- Shared package multdiv_pkg: ADD/SUB mode encoding constants and the default WIDTH/BLOCK constants.
- Sub-module cla_block (parameter BLOCK): purely combinational. Inputs a, b, cin. Outputs sum, block carry-out, carry into the block MSB, and block allp. Instantiated NBLK times via generate.

Test Plan (all with WIDTH=32, BLOCK=8, latency 4):
- Add wraparound: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0, out_ready=1 -> out_sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- Subtract: A=5, B=7, cin=0, sub=1 -> out_sum=0xFFFFFFFE, cout=0, ovf=0; then A=7, B=5 -> 0x00000002, cout=1.
- Signed overflow: A=0x7FFFFFFF, B=1, add -> out_sum=0x80000000, ovf=1, cout=0; A=0x80000000, B=1, sub -> 0x7FFFFFFF, ovf=1.
- Full propagate: A=0xAAAAAAAA, B=0x55555555, cin=1, add -> out_sum=0x00000000, cout=1, allp=1; same with cin=0 -> 0xFFFFFFFF, cout=0.
- Backpressure: 6 back-to-back ops with tags 0..5, out_ready low for 3 cycles once the first result appears -> in_ready low exactly those cycles; results emerge in tag order 0..5 with no loss or duplication; held out_* stable during stall.
- Reset mid-flight: 4 ops in the pipe, pulse reset between edges -> out_valid falls immediately (asynchronously), all outputs 0, no stale result after reset release; a fresh op completes with normal 4-cycle latency.
